spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_tick.sv | 30 +++
 rtl/spi_master.sv | 130 +++++++++++++
 tb/tb_spi_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master.
package spi_pkg;

    localparam int unsigned SPI_DATA_W       = 8;
    localparam int unsigned SPI_CLK_DIV_DEF  = 4;
    localparam int unsigned SPI_LEAD_SCL_DEF = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLead,
        StData,
        StHold,
        StGap
    } spi_mst_state_t;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: reloads to CLK_DIV-1 on load or on expiry, tick is high at zero.
module spi_clk_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic tick
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 8'd1;
        if (load || (cnt_q == 8'd0)) begin
            cnt_d = 8'(CLK_DIV - 1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, with configurable lead-in clocks before the data phase.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = SPI_CLK_DIV_DEF,
    parameter int unsigned LEAD_SCL = SPI_LEAD_SCL_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [SPI_DATA_W-1:0] tx_data,
    output logic                  ready,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  SCL,
    output logic                  CS,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int unsigned HP_W = 9;
    localparam logic [HP_W-1:0] LEAD_LAST = HP_W'(2 * LEAD_SCL - 1);
    localparam logic [HP_W-1:0] DATA_LAST = HP_W'(2 * SPI_DATA_W - 1);
    localparam logic [HP_W-1:0] GAP_LAST  = HP_W'(1);

    spi_mst_state_t        state_q, state_d;
    logic [HP_W-1:0]       hp_q, hp_d;
    logic                  scl_q, scl_d;
    logic                  mosi_q, mosi_d;
    logic [SPI_DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [SPI_DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tick, cnt_load;
    logic                  accept, scl_active, sample, shift_out, frame_done;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_tick (
        .clk    (clk),
        .resetn (resetn),
        .load   (cnt_load),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: if (tick) state_d = (LEAD_SCL == 0) ? StData : StLead;
            StLead:  if (tick && (hp_q == LEAD_LAST)) state_d = StData;
            StData:  if (tick && (hp_q == DATA_LAST)) state_d = StHold;
            StHold:  if (tick) state_d = StGap;
            StGap:   if (tick && (hp_q == GAP_LAST)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        accept     = (state_q == StIdle) && start;
        scl_active = (state_q == StLead) || (state_q == StData);
        sample     = (state_q == StData) && tick && !scl_q;
        // Falling edges in DATA, plus the edge that enters DATA, present the next tx bit.
        shift_out  = tick && (((state_q == StData) && scl_q) ||
                              ((state_q != StData) && (state_d == StData)));
        frame_done = (state_q == StHold) && (state_d == StGap);
        cnt_load   = (state_q == StIdle) || (state_d != state_q);

        hp_d = hp_q;
        if (state_d != state_q) begin
            hp_d = '0;
        end else if (tick) begin
            hp_d = hp_q + HP_W'(1);
        end

        scl_d = 1'b0;
        if (scl_active) begin
            scl_d = tick ? ~scl_q : scl_q;
        end

        mosi_d  = mosi_q;
        tx_sh_d = tx_sh_q;
        if (accept) begin
            mosi_d  = 1'b0;
            tx_sh_d = tx_data;
        end else if (shift_out) begin
            mosi_d  = tx_sh_q[SPI_DATA_W-1];
            tx_sh_d = {tx_sh_q[SPI_DATA_W-2:0], 1'b0};
        end

        rx_sh_d = rx_sh_q;
        if (sample) begin
            rx_sh_d = {rx_sh_q[SPI_DATA_W-2:0], MISO};
        end

        rx_valid_d = frame_done;
        rx_data_d  = frame_done ? rx_sh_q : rx_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            hp_q       <= '0;
            scl_q      <= 1'b0;
            mosi_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            scl_q      <= scl_d;
            mosi_q     <= mosi_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign CS       = !((state_q == StSetup) || (state_q == StLead) ||
                        (state_q == StData)  || (state_q == StHold));
    assign SCL      = scl_q;
    assign MOSI     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: slave model with scoreboard on one instance, loopback on a second.
module tb_spi_master;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] stx;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start_a, start_b;
    logic [7:0] tx_a, tx_b;
    logic       ready_a, ready_b;
    logic [7:0] rxd_a, rxd_b;
    logic       rxv_a, rxv_b;
    logic       scl_a, scl_b, cs_a, cs_b, mosi_a, mosi_b;
    logic       miso_a;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t sb[$];
    vec_t vecs[4];

    // Slave model for instance A.
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_rc = 0;
    logic       cs_prev = 1'b1;
    logic       scl_prev = 1'b0;
    int         valid_a = 0;
    int         cs_falls_a = 0;
    int         rc_b = 0;
    int         valid_b = 0;

    always #5 clk = ~clk;

    spi_master #(
        .CLK_DIV  (2),
        .LEAD_SCL (2)
    ) u_dut_a (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start_a),
        .tx_data  (tx_a),
        .ready    (ready_a),
        .rx_data  (rxd_a),
        .rx_valid (rxv_a),
        .SCL      (scl_a),
        .CS       (cs_a),
        .MOSI     (mosi_a),
        .MISO     (miso_a)
    );

    spi_master #(
        .CLK_DIV  (1),
        .LEAD_SCL (0)
    ) u_dut_b (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start_b),
        .tx_data  (tx_b),
        .ready    (ready_b),
        .rx_data  (rxd_b),
        .rx_valid (rxv_b),
        .SCL      (scl_b),
        .CS       (cs_b),
        .MOSI     (mosi_b),
        .MISO     (mosi_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    always @(cs_a, scl_a) begin
        if (!cs_a && cs_prev) begin
            s_rc     = 0;
            s_sh     = s_tx;
            miso_a   = s_tx[7];
            cs_falls_a++;
        end
        if (scl_a && !scl_prev) begin
            s_rc++;
            if (s_rc > 2) s_rx = {s_rx[6:0], mosi_a};
        end
        if (!scl_a && scl_prev && !cs_a && (s_rc > 2)) begin
            s_sh   = {s_sh[6:0], 1'b0};
            miso_a = s_sh[7];
        end
        cs_prev  = cs_a;
        scl_prev = scl_a;
    end

    always @(posedge scl_b) rc_b++;
    always @(negedge cs_b) rc_b = 0;

    // Scoreboard: each completed frame on A pops one expected record.
    always @(negedge clk) begin
        if (resetn && rxv_a) begin
            vec_t e;
            valid_a++;
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_rx_data", {24'd0, rxd_a}, {24'd0, e.stx});
                check("sb_slave_rx", {24'd0, s_rx}, {24'd0, e.tx});
            end
        end
        if (resetn && rxv_b) valid_b++;
        if (cs_a && scl_a) check("scl_low_when_cs_high_a", 32'd1, 32'd0);
        if (cs_b && scl_b) check("scl_low_when_cs_high_b", 32'd1, 32'd0);
    end

    assert property (@(posedge clk) disable iff (!resetn) $rose(scl_a) |-> $stable(mosi_a))
        else begin n_fail++; $display("FAIL mosi_stable_a: MOSI changed on SCL rise"); end
    assert property (@(posedge clk) disable iff (!resetn) $rose(scl_b) |-> $stable(mosi_b))
        else begin n_fail++; $display("FAIL mosi_stable_b: MOSI changed on SCL rise"); end

    task automatic wait_ready_a();
        for (int i = 0; i < 500 && !ready_a; i++) @(negedge clk);
    endtask

    // Accept one frame on A and return the accept-to-ready latency in cycles.
    task automatic frame_a(input logic [7:0] tx, input logic [7:0] stx, input bit push,
                           output int lat);
        vec_t e;
        e.tx  = tx;
        e.stx = stx;
        s_tx  = stx;
        if (push) sb.push_back(e);
        @(negedge clk);
        wait_ready_a();
        tx_a    = tx;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        tx_a    = ~tx;
        lat     = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_a) break;
        end
    endtask

    task automatic frame_b(input logic [7:0] tx, output int lat);
        @(negedge clk);
        tx_b    = tx;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        tx_b    = 8'h00;
        lat     = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_b) break;
        end
    endtask

    initial begin
        int   lat, v0, f0, hi;
        logic [7:0] bvals[2];

        vecs[0] = '{tx: 8'hA5, stx: 8'h3C};
        vecs[1] = '{tx: 8'hFF, stx: 8'h00};
        vecs[2] = '{tx: 8'h00, stx: 8'hFF};
        vecs[3] = '{tx: 8'h81, stx: 8'h7E};
        bvals[0] = 8'h5A;
        bvals[1] = 8'hC3;

        resetn  = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tx_a    = 8'h00;
        tx_b    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready_a}, 32'd1);
        check("rst_cs", {31'd0, cs_a}, 32'd1);
        check("rst_scl", {31'd0, scl_a}, 32'd0);
        check("rst_mosi", {31'd0, mosi_a}, 32'd0);
        check("rst_rx_data", {24'd0, rxd_a}, 32'd0);
        check("rst_rx_valid", {31'd0, rxv_a}, 32'd0);
        resetn = 1'b1;

        // Table-driven frames on A.
        for (int i = 0; i < 4; i++) begin
            v0 = valid_a;
            frame_a(vecs[i].tx, vecs[i].stx, 1'b1, lat);
            check("vec_latency", lat, 48);
            check("vec_scl_rises", s_rc, 10);
            check("vec_rx_valid_count", valid_a - v0, 1);
        end

        // Back-to-back with start held high; tx_data changes right after accept.
        v0   = valid_a;
        s_tx = 8'h96;
        sb.push_back('{tx: 8'hFF, stx: 8'h96});
        sb.push_back('{tx: 8'h00, stx: 8'h96});
        @(negedge clk);
        wait_ready_a();
        tx_a    = 8'hFF;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_a = 8'h00;
        for (int i = 0; i < 200 && !cs_a; i++) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 100 && cs_a; i++) begin
            hi++;
            @(negedge clk);
        end
        start_a = 1'b0;
        tx_a    = 8'h55;
        check("b2b_cs_gap_ge_4", {31'd0, hi >= 4}, 32'd1);
        repeat (2) @(negedge clk);
        wait_ready_a();
        check("b2b_ready", {31'd0, ready_a}, 32'd1);
        check("b2b_rx_valid_count", valid_a - v0, 2);

        // start pulsed during DATA is ignored.
        v0   = valid_a;
        f0   = cs_falls_a;
        s_tx = 8'h42;
        sb.push_back('{tx: 8'h81, stx: 8'h42});
        @(negedge clk);
        wait_ready_a();
        tx_a    = 8'h81;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 200 && s_rc < 4; i++) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_ready_a();
        repeat (30) @(negedge clk);
        check("ignored_start_cs_falls", cs_falls_a - f0, 1);
        check("ignored_start_rx_valid", valid_a - v0, 1);

        // Reset at the 4th DATA rise aborts the frame.
        v0   = valid_a;
        s_tx = 8'hE7;
        @(negedge clk);
        wait_ready_a();
        tx_a    = 8'hC6;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 5000 && s_rc != 6; i++) #1;
        check("abort_reached_rise", s_rc, 6);
        #1 resetn = 1'b0;
        #1;
        check("abort_cs", {31'd0, cs_a}, 32'd1);
        check("abort_scl", {31'd0, scl_a}, 32'd0);
        check("abort_mosi", {31'd0, mosi_a}, 32'd0);
        check("abort_ready", {31'd0, ready_a}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_rx_data", {24'd0, rxd_a}, 32'd0);
        check("abort_no_valid", valid_a - v0, 0);
        frame_a(8'h3D, 8'hB2, 1'b1, lat);
        check("recover_latency", lat, 48);
        check("recover_valid", valid_a - v0, 1);

        // Loopback on B: CLK_DIV=1, no lead clocks.
        for (int i = 0; i < 2; i++) begin
            v0 = valid_b;
            frame_b(bvals[i], lat);
            check("loop_latency", lat, 20);
            check("loop_scl_rises", rc_b, 8);
            check("loop_rx_data", {24'd0, rxd_b}, {24'd0, bvals[i]});
            check("loop_rx_valid", valid_b - v0, 1);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
